// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 (x^31 + x^28 + 1) bit-error-rate test block.
// Pure definitions only; no timing or flow-control behaviour lives here.
package prbs31_pkg;

  localparam int PRBS_W = 31;
  localparam int TAP_A  = 30;
  localparam int TAP_B  = 27;
  localparam logic [PRBS_W-1:0] SEED_DEFAULT = 31'h1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [PRBS_W-1:0] fix_seed(input logic [PRBS_W-1:0] s);
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

endpackage

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker: 31-sample fill, then compare with a saturating error count.
// Result visible one cycle after each sample; no backpressure, samples only when chk_en is high.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             clr,
  input  logic             rx_bit,
`ifdef PRBS31_ERR_INJECT_EN
  input  logic             err_inj,
`endif
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sat
);

  logic [PRBS_W-1:0] hist_q, hist_d;
  logic [4:0]        fill_q, fill_d;
  logic              locked_q, locked_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              sat_q, sat_d;
  logic              bit_s;
  logic              exp_bit;

  always_comb begin
`ifdef PRBS31_ERR_INJECT_EN
    bit_s = rx_bit ^ err_inj;
`else
    bit_s = rx_bit;
`endif
    exp_bit  = hist_q[TAP_A] ^ hist_q[TAP_B];
    hist_d   = hist_q;
    fill_d   = fill_q;
    locked_d = locked_q;
    err_d    = err_q;
    sat_d    = sat_q;
    if (clr) begin
      hist_d   = '0;
      fill_d   = '0;
      locked_d = 1'b0;
      err_d    = '0;
      sat_d    = 1'b0;
    end else if (chk_en) begin
      // The received bit is always shifted in, so a single error self-heals after 31 samples.
      hist_d = {hist_q[PRBS_W-2:0], bit_s};
      if (!locked_q) begin
        if (fill_q == 5'(PRBS_W - 1)) begin
          locked_d = 1'b1;
        end else begin
          fill_d = fill_q + 5'd1;
        end
      end else if ((bit_s != exp_bit) && !sat_q) begin
        err_d = err_q + 1'b1;
        sat_d = &err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q   <= '0;
      fill_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

  assign locked  = locked_q;
  assign err_cnt = err_q;
  assign err_sat = sat_q;

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 BER sequencer: done pulses start+2+run_len+LOOP_LAT cycles after start; ena=0 stalls all state.
// Optional err_inj input exists only when PRBS31_ERR_INJECT_EN is defined.
module prbs31_bert_ctrl
  import prbs31_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int ERR_W    = 16,
  parameter int LOOP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [PRBS_W-1:0] seed,
  input  logic [LEN_W-1:0]  run_len,
  output logic              gen_load,
  output logic [PRBS_W-1:0] gen_seed,
  output logic              gen_en,
  input  logic              rx_bit,
`ifdef PRBS31_ERR_INJECT_EN
  input  logic              err_inj,
`endif
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_sat
);

  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(LOOP_LAT - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [PRBS_W-1:0]   seed_q, seed_d;
  logic [LOOP_LAT-1:0] dly_q, dly_d;
  logic                gen_load_q, gen_load_d;
  logic                gen_en_q, gen_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    dly_d   = dly_q;
    if (ena) begin
      dly_d = LOOP_LAT'({dly_q, gen_en_q});
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = run_len;
            seed_d  = fix_seed(seed);
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (len_q == '0) begin
            cnt_d   = DRAIN_LAST;
            state_d = DRAIN;
          end else begin
            cnt_d   = len_q;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cnt_q == LEN_W'(1)) begin
            cnt_d   = DRAIN_LAST;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // Abort outranks start and drops anything still in flight toward the checker.
      if (abort) begin
        state_d = IDLE;
        dly_d   = '0;
      end
    end
    gen_load_d = (state_d == LOAD);
    gen_en_d   = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      seed_q     <= '0;
      dly_q      <= '0;
      gen_load_q <= 1'b0;
      gen_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      seed_q     <= seed_d;
      dly_q      <= dly_d;
      gen_load_q <= gen_load_d;
      gen_en_q   <= gen_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign gen_load = gen_load_q & ena;
  assign gen_en   = gen_en_q & ena;
  assign gen_seed = seed_q;
  assign busy     = busy_q;
  assign done     = done_q;

  prbs31_checker #(
    .ERR_W (ERR_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .chk_en  (dly_q[LOOP_LAT-1] & ena),
    .clr     (gen_load_q & ena),
    .rx_bit  (rx_bit),
`ifdef PRBS31_ERR_INJECT_EN
    .err_inj (err_inj),
`endif
    .locked  (locked),
    .err_cnt (err_cnt),
    .err_sat (err_sat)
  );

endmodule
